reveal_ctrl: RTL and testbench

Game-side initiator for the flood-fill engine. Accepts player actions (reveal / flag toggle) at a tile index and owns the `revealed` and `flagged` board registers. For reveals it pulses `ff_start`, waits for `ff_done`, and merges `ff_result_mask` into `revealed`. It then detects loss (mine revealed) and win (every non-mine tile revealed), and sits between the input/cursor logic and `flood_fill`.

---
 rtl/reveal_ctrl_if.sv | 27 ++
 rtl/reveal_ctrl.sv | 128 ++++++++++++
 tb/tb_reveal_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reveal_ctrl_if.sv
// Action handshake and flood_fill request/response bundle for reveal_ctrl.
// The slave side is reveal_ctrl; the master side is cursor logic plus flood_fill.
interface reveal_ctrl_if #(
  parameter int GRID_SIZE = 8
);
  localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE;
  localparam int INDEX_BITS  = $clog2(TOTAL_TILES);

  logic                   act_valid;
  logic                   act_ready;
  logic                   act_type;
  logic [INDEX_BITS-1:0]  act_index;
  logic                   ff_start;
  logic [INDEX_BITS-1:0]  ff_root_index;
  logic [TOTAL_TILES-1:0] ff_result_mask;
  logic                   ff_done;

  modport master (
    output act_valid, act_type, act_index, ff_result_mask, ff_done,
    input  act_ready, ff_start, ff_root_index
  );

  modport slave (
    input  act_valid, act_type, act_index, ff_result_mask, ff_done,
    output act_ready, ff_start, ff_root_index
  );
endinterface

// File: rtl/reveal_ctrl.sv
// Game-side initiator for flood_fill: owns the revealed/flagged maps, issues
// floods for reveals, merges results and tracks win/loss.
module reveal_ctrl #(
  parameter  int GRID_SIZE   = 8,
  localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic [TOTAL_TILES-1:0] mines,
  reveal_ctrl_if.slave           bus,
  output logic [TOTAL_TILES-1:0] revealed,
  output logic [TOTAL_TILES-1:0] flagged,
  output logic                   game_lost,
  output logic                   game_won
);
  localparam int INDEX_BITS = $clog2(TOTAL_TILES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_OVER,
    S_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [TOTAL_TILES-1:0] revealed_q, revealed_d;
  logic [TOTAL_TILES-1:0] flagged_q, flagged_d;
  logic                   game_lost_q, game_lost_d;
  logic                   game_won_q, game_won_d;
  logic                   ff_start_q, ff_start_d;
  logic [INDEX_BITS-1:0]  ff_root_index_q, ff_root_index_d;
  logic                   act_ready;
  logic                   accept;

  assign act_ready = (state_q == S_IDLE) && !new_game;
  assign accept    = bus.act_valid && act_ready;

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    revealed_d      = revealed_q;
    flagged_d       = flagged_q;
    game_lost_d     = game_lost_q;
    game_won_d      = game_won_q;
    ff_start_d      = 1'b0;
    ff_root_index_d = ff_root_index_q;

    if (new_game) begin
      revealed_d  = '0;
      flagged_d   = '0;
      game_lost_d = 1'b0;
      game_won_d  = 1'b0;
      // A flood still in flight must finish before another may be started.
      state_d     = (state_q == S_WAIT || state_q == S_DRAIN) ? S_DRAIN : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.act_type) begin
              if (!revealed_q[bus.act_index])
                flagged_d[bus.act_index] = ~flagged_q[bus.act_index];
            end else if (!flagged_q[bus.act_index] && !revealed_q[bus.act_index]) begin
              if (mines[bus.act_index]) begin
                revealed_d  = revealed_q | mines;
                game_lost_d = 1'b1;
                state_d     = S_OVER;
              end else begin
                ff_root_index_d = bus.act_index;
                ff_start_d      = 1'b1;
                state_d         = S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (bus.ff_done) begin
            revealed_d = revealed_q | (bus.ff_result_mask & ~flagged_q & ~mines);
            state_d    = S_CHECK;
          end
        end
        S_CHECK: begin
          if (&(revealed_q | mines)) begin
            game_won_d = 1'b1;
            state_d    = S_OVER;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_OVER:  state_d = S_OVER;
        S_DRAIN: if (bus.ff_done) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      revealed_q      <= '0;
      flagged_q       <= '0;
      game_lost_q     <= 1'b0;
      game_won_q      <= 1'b0;
      ff_start_q      <= 1'b0;
      ff_root_index_q <= '0;
    end else begin
      state_q         <= state_d;
      revealed_q      <= revealed_d;
      flagged_q       <= flagged_d;
      game_lost_q     <= game_lost_d;
      game_won_q      <= game_won_d;
      ff_start_q      <= ff_start_d;
      ff_root_index_q <= ff_root_index_d;
    end
  end

  assign bus.act_ready     = act_ready;
  assign bus.ff_start      = ff_start_q;
  assign bus.ff_root_index = ff_root_index_q;
  assign revealed          = revealed_q;
  assign flagged           = flagged_q;
  assign game_lost         = game_lost_q;
  assign game_won          = game_won_q;
endmodule

// File: tb/tb_reveal_ctrl.sv
// Self-checking bench for reveal_ctrl: table of back-to-back actions, directed
// corner sequences and randomized games against a tile-level reference model.
module tb_reveal_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_game = 1'b0;
  logic [63:0] mines = '0;
  logic [63:0] revealed, flagged;
  logic        game_lost, game_won;

  int checks = 0;
  int errors = 0;

  reveal_ctrl_if #(.GRID_SIZE(8)) bus ();

  reveal_ctrl #(.GRID_SIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .new_game  (new_game),
    .mines     (mines),
    .bus       (bus),
    .revealed  (revealed),
    .flagged   (flagged),
    .game_lost (game_lost),
    .game_won  (game_won)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        typ;
    int          idx;
    logic [63:0] exp_flag;
    logic [63:0] exp_rev;
  } vec_t;

  vec_t vecs[9];

  // Tile-level reference model
  bit   m_mine[64];
  bit   m_rev[64];
  bit   m_flag[64];
  logic m_lost, m_won;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  function automatic logic [63:0] to_vec(input bit a[64]);
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[k] = a[k];
    return v;
  endfunction

  function automatic logic [63:0] bit_at(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  initial begin
    bus.act_valid      = 1'b0;
    bus.act_type       = 1'b0;
    bus.act_index      = '0;
    bus.ff_done        = 1'b0;
    bus.ff_result_mask = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("rst_revealed", revealed, 64'd0);
    check("rst_flagged", flagged, 64'd0);
    check("rst_lost", game_lost, 0);
    check("rst_won", game_won, 0);
    check("rst_ff_start", bus.ff_start, 0);
    check("rst_root", bus.ff_root_index, 0);
    @(negedge clk);
    check("rst_ready", bus.act_ready, 1);
    tick();

    // Back-to-back flag/no-op table on a board with mines at 9 and 20
    mines = bit_at(9) | bit_at(20);
    do_new_game();
    vecs[0] = '{1'b1, 5,  bit_at(5), 64'd0};
    vecs[1] = '{1'b1, 5,  64'd0, 64'd0};
    vecs[2] = '{1'b1, 3,  bit_at(3), 64'd0};
    vecs[3] = '{1'b0, 3,  bit_at(3), 64'd0};
    vecs[4] = '{1'b1, 63, bit_at(3) | bit_at(63), 64'd0};
    vecs[5] = '{1'b0, 63, bit_at(3) | bit_at(63), 64'd0};
    vecs[6] = '{1'b1, 9,  bit_at(3) | bit_at(63) | bit_at(9), 64'd0};
    vecs[7] = '{1'b0, 9,  bit_at(3) | bit_at(63) | bit_at(9), 64'd0};
    vecs[8] = '{1'b1, 9,  bit_at(3) | bit_at(63), 64'd0};
    bus.act_valid = 1'b1;
    for (int v = 0; v < 9; v++) begin
      bus.act_type  = vecs[v].typ;
      bus.act_index = vecs[v].idx[5:0];
      @(negedge clk);
      check($sformatf("tbl%0d_ready", v), bus.act_ready, 1);
      tick();
      check($sformatf("tbl%0d_flagged", v), flagged, vecs[v].exp_flag);
      check($sformatf("tbl%0d_revealed", v), revealed, vecs[v].exp_rev);
      check($sformatf("tbl%0d_ff_start", v), bus.ff_start, 0);
      check($sformatf("tbl%0d_lost", v), game_lost, 0);
    end

    // Mine hit: reveal idx 9
    bus.act_type  = 1'b0;
    bus.act_index = 6'd9;
    tick();
    check("mine_revealed", revealed, bit_at(9) | bit_at(20));
    check("mine_lost", game_lost, 1);
    check("mine_ff_start", bus.ff_start, 0);
    bus.act_type  = 1'b1;
    bus.act_index = 6'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("over_ready", bus.act_ready, 0);
      check("over_ff_start", bus.ff_start, 0);
      tick();
    end
    check("over_flagged", flagged, bit_at(3) | bit_at(63));
    bus.act_valid = 1'b0;

    // Single flood to a win: mine only at 63, latency 10
    mines = bit_at(63);
    do_new_game();
    check("ng_clear_rev", revealed, 64'd0);
    check("ng_clear_lost", game_lost, 0);
    bus.act_valid = 1'b1;
    bus.act_type  = 1'b0;
    bus.act_index = 6'd0;
    tick();
    bus.act_valid = 1'b0;
    check("flood_start_hi", bus.ff_start, 1);
    check("flood_root", bus.ff_root_index, 0);
    tick();
    check("flood_start_lo", bus.ff_start, 0);
    repeat (8) begin
      check("flood_start_quiet", bus.ff_start, 0);
      tick();
    end
    bus.ff_done        = 1'b1;
    bus.ff_result_mask = 64'h7FFF_FFFF_FFFF_FFFF;
    tick();
    bus.ff_done = 1'b0;
    check("flood_revealed", revealed, 64'h7FFF_FFFF_FFFF_FFFF);
    check("flood_won_d1", game_won, 0);
    tick();
    check("flood_won_d2", game_won, 1);
    @(negedge clk);
    check("flood_won_ready", bus.act_ready, 0);
    tick();

    // Flag protection
    do_new_game();
    check("ng_clear_won", game_won, 0);
    bus.act_valid = 1'b1;
    bus.act_type  = 1'b1;
    bus.act_index = 6'd3;
    tick();
    bus.act_type = 1'b0;
    tick();
    bus.act_valid = 1'b0;
    check("prot_no_start", bus.ff_start, 0);
    check("prot_rev0", revealed, 64'd0);
    bus.act_valid = 1'b1;
    bus.act_index = 6'd4;
    tick();
    bus.act_valid = 1'b0;
    check("prot_root", bus.ff_root_index, 4);
    check("prot_start", bus.ff_start, 1);
    tick();
    bus.ff_done        = 1'b1;
    bus.ff_result_mask = bit_at(3) | bit_at(4);
    tick();
    bus.ff_done = 1'b0;
    check("prot_rev4", revealed, bit_at(4));
    tick();
    check("prot_not_won", game_won, 0);
    bus.act_valid = 1'b1;
    bus.act_type  = 1'b1;
    bus.act_index = 6'd4;
    @(negedge clk);
    check("prot_ready", bus.act_ready, 1);
    tick();
    bus.act_valid = 1'b0;
    check("prot_flag_rev", flagged, bit_at(3));

    // new_game mid-flood, plus a repeat new_game while draining
    do_new_game();
    bus.act_valid = 1'b1;
    bus.act_type  = 1'b1;
    bus.act_index = 6'd10;
    tick();
    bus.act_type  = 1'b0;
    bus.act_index = 6'd0;
    tick();
    bus.act_valid = 1'b0;
    check("mid_start", bus.ff_start, 1);
    tick();
    tick();
    new_game = 1'b1;
    @(negedge clk);
    check("mid_ng_ready", bus.act_ready, 0);
    tick();
    new_game = 1'b0;
    check("mid_flag_clr", flagged, 64'd0);
    check("mid_rev_clr", revealed, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("drain_ready", bus.act_ready, 0);
      tick();
    end
    do_new_game();
    @(negedge clk);
    check("drain_ng_ready", bus.act_ready, 0);
    tick();
    bus.ff_done        = 1'b1;
    bus.ff_result_mask = '1;
    tick();
    bus.ff_done = 1'b0;
    check("drain_rev", revealed, 64'd0);
    check("drain_no_start", bus.ff_start, 0);
    @(negedge clk);
    check("drain_done_ready", bus.act_ready, 1);
    tick();
    check("drain_rev_late", revealed, 64'd0);

    // Simultaneous new_game and reveal
    bus.act_valid = 1'b1;
    bus.act_type  = 1'b0;
    bus.act_index = 6'd7;
    new_game      = 1'b1;
    @(negedge clk);
    check("sim_ready", bus.act_ready, 0);
    tick();
    new_game      = 1'b0;
    bus.act_valid = 1'b0;
    check("sim_no_start", bus.ff_start, 0);
    check("sim_rev", revealed, 64'd0);
    @(negedge clk);
    check("sim_idle", bus.act_ready, 1);
    tick();

    // Randomized games against the reference model
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 64; k++) begin
        m_mine[k] = ($urandom_range(0, 11) == 0);
        m_rev[k]  = 1'b0;
        m_flag[k] = 1'b0;
      end
      m_lost = 1'b0;
      m_won  = 1'b0;
      mines  = to_vec(m_mine);
      do_new_game();
      for (int a = 0; a < 30; a++) begin
        logic        typ, flood;
        int          idx, lat, need, got;
        logic [63:0] mask;
        typ = ($urandom_range(0, 9) < 3);
        idx = $urandom_range(0, 63);
        bus.act_valid = 1'b1;
        bus.act_type  = typ;
        bus.act_index = idx[5:0];
        @(negedge clk);
        check("rnd_ready", bus.act_ready, !(m_lost || m_won));
        tick();
        bus.act_valid = 1'b0;
        if (m_lost || m_won) break;
        flood = 1'b0;
        if (typ) begin
          if (!m_rev[idx]) m_flag[idx] = !m_flag[idx];
        end else if (!m_flag[idx] && !m_rev[idx]) begin
          if (m_mine[idx]) begin
            for (int k = 0; k < 64; k++) if (m_mine[k]) m_rev[k] = 1'b1;
            m_lost = 1'b1;
          end else begin
            flood = 1'b1;
          end
        end
        check("rnd_start", bus.ff_start, flood);
        if (flood) begin
          check("rnd_root", bus.ff_root_index, idx);
          tick();
          check("rnd_start_lo", bus.ff_start, 0);
          lat = $urandom_range(0, 4);
          repeat (lat) tick();
          mask = {$urandom, $urandom} & {$urandom, $urandom};
          bus.ff_done        = 1'b1;
          bus.ff_result_mask = mask;
          tick();
          bus.ff_done = 1'b0;
          for (int k = 0; k < 64; k++)
            if (mask[k] && !m_flag[k] && !m_mine[k]) m_rev[k] = 1'b1;
          check("rnd_flood_rev", revealed, to_vec(m_rev));
          check("rnd_won_early", game_won, 0);
          tick();
          need = 0;
          got  = 0;
          for (int k = 0; k < 64; k++) begin
            if (!m_mine[k]) need++;
            if (!m_mine[k] && m_rev[k]) got++;
          end
          m_won = (need == got);
          check("rnd_won", game_won, m_won);
        end
        check("rnd_rev", revealed, to_vec(m_rev));
        check("rnd_flag", flagged, to_vec(m_flag));
        check("rnd_lost", game_lost, m_lost);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
